// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
// Purely declarative: no latency, no flow control.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is listed first.
  localparam logic [15:0][6:0] HEX2SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] digit_onehot_n(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-data load port and board pin bundle for seg7_scan_driver.
// Signal bundle only; load is always accepted, so there is no backpressure.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load_pending;
  logic        frame_tick;
  logic [3:0]  an_n;
  seg_t        seg_n;
  logic        dp_n;

  modport master (
    output load, digits_in, dp_in,
    input  load_pending, frame_tick, an_n, seg_n, dp_n
  );

  modport slave (
    input  load, digits_in, dp_in,
    output load_pending, frame_tick, an_n, seg_n, dp_n
  );

endinterface

// File: rtl/seg7_scan_driver_decoder.sv
// Combinational hex nibble to active-low segment lookup.
// Zero latency, no flow control.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = HEX2SEG[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver, double-buffered per frame; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Pins registered 1 clk after scan/active change; load always accepted (no backpressure), last load per frame wins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int PRESC_W = $clog2(SCAN_DIV);

  generate
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
  endgenerate

  logic [PRESC_W-1:0] r_presc;
  digit_idx_t         r_scan_idx;
  logic [19:0]        r_shadow;
  logic [19:0]        r_active;
  logic               r_pending;
  logic               r_frame_tick;
  logic [3:0]         r_an_n;
  seg_t               r_seg_n;
  logic               r_dp_n;

  logic        w_tick;
  logic        w_boundary;
  logic [19:0] w_new;
  logic [15:0] w_act_dig;
  logic [3:0]  w_act_dp;
  logic [3:0]  w_nib;
  logic        w_dp;
  logic        w_blank;
  seg_t        w_seg;

  assign w_tick     = (r_presc == PRESC_W'(SCAN_DIV - 1));
  assign w_boundary = w_tick && (r_scan_idx == 2'd3);
  assign w_new      = {bus.dp_in, bus.digits_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_scan_idx <= '0;
    end else if (w_tick) begin
      r_presc    <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_presc    <= r_presc + PRESC_W'(1);
    end
  end

  // A load landing on the boundary bypasses the shadow so it is not held a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (bus.load && w_boundary) begin
        r_active  <= w_new;
        r_shadow  <= w_new;
        r_pending <= 1'b0;
      end else if (bus.load) begin
        r_shadow  <= w_new;
        r_pending <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  assign w_act_dig = r_active[15:0];
  assign w_act_dp  = r_active[19:16];
  assign w_nib     = w_act_dig[{r_scan_idx, 2'b00} +: 4];
  assign w_dp      = w_act_dp[r_scan_idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (r_scan_idx)
      2'd3:    w_blank = (w_act_dig[15:12] == 4'h0);
      2'd2:    w_blank = (w_act_dig[15:8]  == 8'h00);
      2'd1:    w_blank = (w_act_dig[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  seg7_decoder u_decoder (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // A lit decimal point keeps the anode on even when the digit itself is blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_n  <= AN_OFF;
      r_seg_n <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else begin
      r_an_n  <= (w_blank && !w_dp) ? AN_OFF : digit_onehot_n(r_scan_idx);
      r_seg_n <= w_blank ? SEG_BLANK : w_seg;
      r_dp_n  <= ~w_dp;
    end
  end

  assign bus.load_pending = r_pending;
  assign bus.frame_tick   = r_frame_tick;
  assign bus.an_n         = r_an_n;
  assign bus.seg_n        = r_seg_n;
  assign bus.dp_n         = r_dp_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at SCAN_DIV=4: table-driven loads with a per-frame scoreboard.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [15:0]      dig;
    logic [3:0]       dp;
    logic [3:0][6:0]  seg;
    logic [3:0][3:0]  an;
    logic [3:0]       dpn;
  } vec_t;

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  vec_t exp_q[$];
  vec_t tbl[5];
  vec_t v_zero, v_2222, v_0009;

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p,
                              input logic [3:0][6:0] s, input logic [3:0][3:0] a);
    vec_t v;
    v.dig = d;
    v.dp  = p;
    v.seg = s;
    v.an  = a;
    v.dpn = ~p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic clk1();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) clk1();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = p;
    clk1();
    bus.load      = 1'b0;
  endtask

  task automatic wait_frame();
    int lim;
    lim = cyc + 40;
    do clk1(); while (!bus.frame_tick && cyc < lim);
    chk("frame_tick seen", 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " an_n"},         32'(bus.an_n),         32'hF);
    chk({tag, " seg_n"},        32'(bus.seg_n),        32'h7F);
    chk({tag, " dp_n"},         32'(bus.dp_n),         32'd1);
    chk({tag, " frame_tick"},   32'(bus.frame_tick),   32'd0);
    chk({tag, " load_pending"}, 32'(bus.load_pending), 32'd0);
  endtask

  task automatic check_frame(input vec_t v, input int fs);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        run_to(fs + 4*d + k);
        chk($sformatf("an_n d%0d", d),  32'(bus.an_n),  32'(v.an[d]));
        chk($sformatf("seg_n d%0d", d), 32'(bus.seg_n), 32'(v.seg[d]));
        chk($sformatf("dp_n d%0d", d),  32'(bus.dp_n),  32'(v.dpn[d]));
        chk($sformatf("frame_tick d%0d k%0d", d, k), 32'(bus.frame_tick),
            (d == 3 && k == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic pop_and_check();
    vec_t v;
    chk("scoreboard depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check_frame(v, cyc + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int nb;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    v_zero = mk(16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'b1110});
    v_0009 = mk(16'h0009, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h10}, {4'hF, 4'hF, 4'hF, 4'b1110});
    tbl[1] = mk(16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, {4'hF, 4'hF, 4'b1101, 4'b1110});
    tbl[3] = mk(16'h0B07, 4'b1000, {7'h7F, 7'h03, 7'h40, 7'h78}, AN_ALL);
`else
    v_zero = mk(16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, AN_ALL);
    v_0009 = mk(16'h0009, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h10}, AN_ALL);
    tbl[1] = mk(16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, AN_ALL);
    tbl[3] = mk(16'h0B07, 4'b1000, {7'h40, 7'h03, 7'h40, 7'h78}, AN_ALL);
`endif
    tbl[0] = mk(16'h12AF, 4'b0100, {7'h79, 7'h24, 7'h08, 7'h0E}, AN_ALL);
    tbl[2] = mk(16'h8C3D, 4'b1001, {7'h00, 7'h46, 7'h30, 7'h21}, AN_ALL);
    tbl[4] = mk(16'h6E94, 4'b0010, {7'h02, 7'h06, 7'h10, 7'h19}, AN_ALL);
    v_2222 = mk(16'h2222, 4'b0000, {7'h24, 7'h24, 7'h24, 7'h24}, AN_ALL);

    // Reset state, then two idle frames showing zero.
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst = 1'b0;
    cyc = 0;
    check_frame(v_zero, 1);
    check_frame(v_zero, 17);

    // Mid-frame loads from the table, committed at the following boundary.
    for (int i = 0; i < 5; i++) begin
      run_to(cyc + 5);
      do_load(tbl[i].dig, tbl[i].dp);
      exp_q.push_back(tbl[i]);
      chk($sformatf("pending after load %0d", i), 32'(bus.load_pending), 32'd1);
      nb = ((cyc / 16) + 1) * 16;
      run_to(nb - 1);
      chk($sformatf("pending before boundary %0d", i), 32'(bus.load_pending), 32'd1);
      wait_frame();
      chk($sformatf("pending at boundary %0d", i), 32'(bus.load_pending), 32'd0);
      pop_and_check();
    end

    // Two loads in one frame: only the later one is ever shown.
    run_to(cyc + 2);
    do_load(16'h1111, 4'b0000);
    run_to(cyc + 5);
    do_load(16'h2222, 4'b0000);
    exp_q.push_back(v_2222);
    nb = ((cyc / 16) + 1) * 16;
    run_to(nb - 1);
    chk("pending double load", 32'(bus.load_pending), 32'd1);
    wait_frame();
    chk("pending cleared double load", 32'(bus.load_pending), 32'd0);
    pop_and_check();

    // Load coincident with the boundary cycle commits immediately.
    run_to(cyc + 15);
    bus.load      = 1'b1;
    bus.digits_in = 16'h0009;
    bus.dp_in     = 4'b0000;
    clk1();
    bus.load      = 1'b0;
    chk("bypass frame_tick", 32'(bus.frame_tick), 32'd1);
    chk("bypass pending", 32'(bus.load_pending), 32'd0);
    exp_q.push_back(v_0009);
    pop_and_check();

    // Asynchronous reset during digit 2 with a load pending.
    f0 = cyc;
    run_to(f0 + 3);
    do_load(16'h8C3D, 4'b1001);
    chk("pending before reset", 32'(bus.load_pending), 32'd1);
    run_to(f0 + 10);
    chk("an_n in digit 2 slot", 32'(bus.an_n), 32'(v_0009.an[2]));
    #1 rst = 1'b1;
    #1;
    check_reset_vals("async rst");
    @(posedge clk);
    #2;
    check_reset_vals("held rst");
    rst = 1'b0;
    cyc = 0;
    check_frame(v_zero, 1);
    check_frame(v_zero, 17);
    chk("pending discarded", 32'(bus.load_pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Internal prescaler generates a scan tick.
- A 2-bit digit-scan counter (wraps 3->0) selects one digit per tick.
- Displayed value is double-buffered: new data commits only at a frame boundary, so no partial-frame tearing.
- Sits downstream of the counter/datapath logic and drives the board anode/segment pins directly.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot. Legal range is >= 2; elaboration error otherwise.
- PRESC_W, $clog2(SCAN_DIV): prescaler width (derived, localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  one-cycle strobe; capture digits_in/dp_in into the shadow buffer.
- digits_in  in  16  four hex nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
- dp_in  in  4  decimal-point enables, bit i = digit i, active-high.
- load_pending  out  1  shadow holds data not yet committed.
- frame_tick  out  1  one-cycle pulse when digit 3's slot ends (frame boundary).
- an_n  out  4  anode enables, active-low, one-hot-low.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high; every register below is async-reset.
- Reset values:
  - presc=0, scan_idx=0, shadow=0, active=0, pending=0.
  - an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_tick=0, load_pending=0.
- Prescaler:
  - presc increments every cycle.
  - tick = (presc == SCAN_DIV-1); on tick, presc <= 0.
- Scan counter:
  - On tick, scan_idx <= scan_idx+1, 2-bit wrap 3->0.
  - Boundary = tick && scan_idx==3.
- Load and commit:
  - load with no boundary: shadow <= {dp_in, digits_in}, pending <= 1. Last load before a boundary wins.
  - boundary with pending: active <= shadow, pending <= 0.
  - load and boundary in the same cycle: bypass. active <= {dp_in, digits_in}, shadow <= same, pending <= 0.
  - load_pending = pending (registered).
- frame_tick <= boundary (registered). It fires every frame, whether or not a commit occurs.
- Outputs: registered from current scan_idx and active, so latency is 1 cycle after a scan_idx or active change.
  - an_n <= ~(4'b0001 << scan_idx).
  - seg_n <= decode(active nibble[scan_idx]).
  - dp_n <= ~active_dp[scan_idx].
  - First cycle after reset release: an_n=4'b1110, seg_n=7'h40 ('0').
- Decode (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset mid-frame: immediate return to reset values. A pending load is discarded.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit i (i = 3..1) is blanked when its nibble and all higher nibbles of active are 0.
  - Blanked means an_n all 1s and seg_n=7'h7F for that slot.
  - dp_n is still driven from dp for that slot; a set dp un-blanks the anode only.
  - Digit 0 is never blanked.
- Undefined: all four digits are always displayed, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F.
  - 16-entry hex-to-segment constant table.
  - Digit-index typedef (2-bit).
  - AN_OFF = 4'hF.
- Sub-module seg7_decoder: combinational nibble -> seg_n lookup from the package table, instantiated once in the output mux path.
- Prescaler, scan counter, shadow/commit logic and output registers stay in the top module.

Test Plan (SCAN_DIV=4 for simulation):
1. Reset release, no load -> an_n cycles 1110,1101,1011,0111 every 4 clks; seg_n=40 in every slot; frame_tick pulses once per 16 clks.
2. load digits_in=16'h12AF, dp_in=4'b0100 mid-frame -> load_pending=1 until the next boundary. From the following slot, digit 0 shows 0E, digit 1 shows 08, digit 2 shows 24 with dp_n=0, digit 3 shows 79.
3. Two loads (16'h1111, then 16'h2222) in the same frame -> only 2222 is ever displayed; load_pending clears at the boundary.
4. load coincident with boundary cycle (16'h0009) -> committed immediately; load_pending stays 0; the next slot (digit 0) shows 10.
5. Assert rst during digit 2 with a load pending -> outputs go to 1111/7F/1 asynchronously; after release, 0000 is displayed and the pending data is discarded.
6. With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0050:
   - digit 3 slot: an_n=1111, seg_n=7F.
   - digit 2 slot: an_n=1111, seg_n=7F.
   - digit 1 slot: shows 12.
   - digit 0 slot: shows 40.
   
   Without the macro, all four digits are displayed.
